xgmm_writer: RTL and testbench

Write-side engine of the graphics memory manager. Drains the pattern and attribute FIFOs of the graphics register interface, one word at a time. Each word goes into the pattern RAM (4096×16) or attribute RAM (8192×16) at the address the register interface presents when the word is taken. Video fetch owns each RAM port whenever its busy flag is high; this block only writes in the remaining cycles.

---
 rtl/xgmm_pkg.sv | 14 +
 rtl/xgmm_chan.sv | 70 +++++++
 rtl/xgmm_writer.sv | 63 ++++++
 tb/tb_xgmm_writer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xgmm_pkg.sv
// Shared types and sizes for the graphics memory manager write engine.
package xgmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } chan_state_t;

  localparam int XG_PAT_AW  = 12;
  localparam int XG_ATTR_AW = 13;
  localparam int XG_DW      = 16;

endpackage

// File: rtl/xgmm_chan.sv
// One FIFO-to-RAM write channel: capture head word, pop it, then write it
// in the first cycle video fetch does not own the RAM port.
module xgmm_chan
  import xgmm_pkg::*;
#(
  parameter int AW = XG_PAT_AW,
  parameter int DW = XG_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          empty_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] addr_i,
  input  logic          busy_i,
  output logic          pop_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          idle_o
);

  chan_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Address and data are frozen at capture; later register updates from
  // the register interface must not leak into the word in flight.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop_o   = 1'b0;
    we_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_i) begin
          addr_d  = addr_i;
          data_d  = data_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pop_o   = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        we_o = ~busy_i;
        if (!busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_o  = addr_q;
  assign wdata_o = data_q;
  assign idle_o  = (state_q == IDLE);

endmodule

// File: rtl/xgmm_writer.sv
// Write-side engine: drains pattern and attribute FIFOs into their RAMs
// through two independent channels that never arbitrate against each other.
module xgmm_writer
  import xgmm_pkg::*;
#(
  parameter int PAT_AW  = XG_PAT_AW,
  parameter int ATTR_AW = XG_ATTR_AW,
  parameter int DW      = XG_DW
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               p_empty,
  input  logic [DW-1:0]      p_data,
  input  logic [PAT_AW-1:0]  par,
  output logic               p_pop,
  input  logic               a_empty,
  input  logic [DW-1:0]      a_data,
  input  logic [ATTR_AW-1:0] aar,
  output logic               a_pop,
  input  logic               pat_busy,
  output logic               pat_we,
  output logic [PAT_AW-1:0]  pat_addr,
  output logic [DW-1:0]      pat_wdata,
  input  logic               attr_busy,
  output logic               attr_we,
  output logic [ATTR_AW-1:0] attr_addr,
  output logic [DW-1:0]      attr_wdata,
  output logic               idle
);

  logic pat_idle, attr_idle;

  xgmm_chan #(.AW(PAT_AW), .DW(DW)) u_pat (
    .clk_i   (clk_sys),
    .rst_ni  (rst_n),
    .empty_i (p_empty),
    .data_i  (p_data),
    .addr_i  (par),
    .busy_i  (pat_busy),
    .pop_o   (p_pop),
    .we_o    (pat_we),
    .addr_o  (pat_addr),
    .wdata_o (pat_wdata),
    .idle_o  (pat_idle)
  );

  xgmm_chan #(.AW(ATTR_AW), .DW(DW)) u_attr (
    .clk_i   (clk_sys),
    .rst_ni  (rst_n),
    .empty_i (a_empty),
    .data_i  (a_data),
    .addr_i  (aar),
    .busy_i  (attr_busy),
    .pop_o   (a_pop),
    .we_o    (attr_we),
    .addr_o  (attr_addr),
    .wdata_o (attr_wdata),
    .idle_o  (attr_idle)
  );

  assign idle = pat_idle & attr_idle;

endmodule

// File: tb/tb_xgmm_writer.sv
// Directed bench with FIFO models and a write scoreboard drained by a monitor.
module tb_xgmm_writer;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] par = '0;
  logic [12:0] aar = '0;
  logic        pat_busy = 1'b0, attr_busy = 1'b0;
  logic        p_empty, a_empty, p_pop, a_pop, pat_we, attr_we, idle;
  logic [15:0] p_data, a_data, pat_wdata, attr_wdata;
  logic [11:0] pat_addr;
  logic [12:0] attr_addr;

  // FIFO models: stimulus owns write side, pop process owns read side
  logic [15:0] pmem [0:15];
  logic [15:0] amem [0:15];
  logic [3:0]  pwr = '0, prd = '0, awr = '0, ard = '0;
  assign p_empty = (pwr == prd);
  assign a_empty = (awr == ard);
  assign p_data  = pmem[prd];
  assign a_data  = amem[ard];

  always @(posedge clk_sys) begin
    if (p_pop) prd <= prd + 4'd1;
    if (a_pop) ard <= ard + 4'd1;
  end

  always #5 clk_sys = ~clk_sys;

  xgmm_writer dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .p_empty(p_empty), .p_data(p_data), .par(par), .p_pop(p_pop),
    .a_empty(a_empty), .a_data(a_data), .aar(aar), .a_pop(a_pop),
    .pat_busy(pat_busy), .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata),
    .attr_busy(attr_busy), .attr_we(attr_we), .attr_addr(attr_addr), .attr_wdata(attr_wdata),
    .idle(idle)
  );

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t pexp[$];
  wr_t aexp[$];
  int  acyc[$];
  int  checks = 0, failures = 0;
  int  cyc = 0;
  int  n_ppop = 0, n_apop = 0, n_pwe = 0, n_awe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_p(input logic [15:0] d, input logic [11:0] a);
    pmem[pwr] = d;
    pwr = pwr + 4'd1;
    pexp.push_back('{addr: {1'b0, a}, data: d});
  endtask

  task automatic push_a(input logic [15:0] d, input logic [12:0] a);
    amem[awr] = d;
    awr = awr + 4'd1;
    aexp.push_back('{addr: a, data: d});
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk_sys);
      if (rst_n) begin
        if (p_pop) n_ppop++;
        if (a_pop) n_apop++;
        if (pat_we) begin
          n_pwe++;
          if (pexp.size() == 0) chk("pat_unexpected_write", 32'd1, 32'd0);
          else begin
            e = pexp.pop_front();
            chk("pat_addr", {20'd0, pat_addr}, {19'd0, e.addr});
            chk("pat_wdata", {16'd0, pat_wdata}, {16'd0, e.data});
          end
        end
        if (attr_we) begin
          n_awe++;
          acyc.push_back(cyc);
          if (aexp.size() == 0) chk("attr_unexpected_write", 32'd1, 32'd0);
          else begin
            e = aexp.pop_front();
            chk("attr_addr", {19'd0, attr_addr}, {19'd0, e.addr});
            chk("attr_wdata", {16'd0, attr_wdata}, {16'd0, e.data});
          end
        end
      end
    end
  endtask

  initial begin
    int base_pwe, base_ppop, base_awe, base_apop;
    fork
      forever begin @(posedge clk_sys); cyc++; end
      monitor();
    join_none

    // Reset state
    #12;
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_p_pop", {31'd0, p_pop}, 32'd0);
    chk("rst_pat_we", {31'd0, pat_we}, 32'd0);
    chk("rst_attr_we", {31'd0, attr_we}, 32'd0);
    chk("rst_pat_addr", {20'd0, pat_addr}, 32'd0);
    chk("rst_attr_wdata", {16'd0, attr_wdata}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single pattern word
    par = 12'h123;
    push_p(16'hA5A5, 12'h123);
    tick();
    chk("t2_pop_c1", {31'd0, p_pop}, 32'd1);
    chk("t2_we_c1", {31'd0, pat_we}, 32'd0);
    chk("t2_idle_c1", {31'd0, idle}, 32'd0);
    tick();
    chk("t2_pop_c2", {31'd0, p_pop}, 32'd0);
    chk("t2_we_c2", {31'd0, pat_we}, 32'd1);
    tick();
    chk("t2_we_c3", {31'd0, pat_we}, 32'd0);
    chk("t2_idle_c3", {31'd0, idle}, 32'd1);
    tick();

    // Four attribute words at a fixed top address
    aar = 13'h1FFF;
    base_awe = n_awe; base_apop = n_apop;
    acyc.delete();
    push_a(16'h1111, 13'h1FFF);
    push_a(16'h2222, 13'h1FFF);
    push_a(16'h3333, 13'h1FFF);
    push_a(16'h4444, 13'h1FFF);
    repeat (15) tick();
    chk("t3_apop_count", n_apop - base_apop, 32'd4);
    chk("t3_awe_count", n_awe - base_awe, 32'd4);
    for (int i = 1; i < acyc.size(); i++)
      chk("t3_write_spacing", acyc[i] - acyc[i-1], 32'd3);
    chk("t3_idle", {31'd0, idle}, 32'd1);

    // Busy stretch with address register changing under the held word
    base_pwe = n_pwe;
    par = 12'h123;
    push_p(16'hBEEF, 12'h123);
    tick();
    pat_busy = 1'b1;
    par = 12'h456;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_we_while_busy", {31'd0, pat_we}, 32'd0);
      chk("t4_addr_held", {20'd0, pat_addr}, 32'h123);
      if (i < 4) tick();
    end
    tick();
    pat_busy = 1'b0;
    #1;
    chk("t4_we_on_release", {31'd0, pat_we}, 32'd1);
    tick();
    tick();
    chk("t4_single_write", n_pwe - base_pwe, 32'd1);

    // Both channels together
    par = 12'h0AB; aar = 13'h0CD;
    base_ppop = n_ppop; base_apop = n_apop;
    push_p(16'h1234, 12'h0AB);
    push_a(16'h5678, 13'h0CD);
    tick();
    chk("t5_pops_together", {30'd0, p_pop, a_pop}, 32'd3);
    chk("t5_idle_load", {31'd0, idle}, 32'd0);
    tick();
    chk("t5_we_together", {30'd0, pat_we, attr_we}, 32'd3);
    chk("t5_idle_write", {31'd0, idle}, 32'd0);
    tick();
    chk("t5_idle_after", {31'd0, idle}, 32'd1);
    chk("t5_pop_counts", (n_ppop - base_ppop) * 16 + (n_apop - base_apop), 32'h11);
    tick();

    // Reset while held in WRITE: word is lost, no write afterwards
    base_pwe = n_pwe;
    par = 12'h321;
    pmem[pwr] = 16'hDEAD;
    pwr = pwr + 4'd1;
    tick();
    pat_busy = 1'b1;
    tick();
    chk("t6_we_busy", {31'd0, pat_we}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_idle", {31'd0, idle}, 32'd1);
    chk("t6_rst_pat_addr", {20'd0, pat_addr}, 32'd0);
    chk("t6_rst_pat_wdata", {16'd0, pat_wdata}, 32'd0);
    chk("t6_rst_p_pop", {31'd0, p_pop}, 32'd0);
    tick();
    pat_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t6_no_write_after", n_pwe - base_pwe, 32'd0);
    chk("t6_idle_after", {31'd0, idle}, 32'd1);

    chk("pat_sb_empty", pexp.size(), 32'd0);
    chk("attr_sb_empty", aexp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
